// File: rtl/seg_scan_sched.sv
// Scan controller for a 4-digit common-anode 7-segment display: blanking gap, blink, dp.
// Optional macro SEG_SCAN_LZ_BLANK_EN enables leading-zero suppression on digits 3..1.
module seg_scan_sched #(
   parameter int unsigned SCAN_DIV     = 25000,
   parameter int unsigned BLANK_CYC    = 250,
   parameter int unsigned BLINK_FRAMES = 500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [15:0] data_in,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  blink_mask,
   output logic [3:0]  dig,
   output logic [7:0]  seg,
   output logic [1:0]  scan_idx,
   output logic        frame_done
);

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

   localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYC - 1);
   localparam logic [15:0] SHOW_LAST  = 16'(SCAN_DIV - BLANK_CYC - 1);
   localparam logic [9:0]  FRAME_LAST = 10'(BLINK_FRAMES - 1);

   state_t      r_state;
   logic [15:0] r_cnt;
   logic [9:0]  r_fcnt;
   logic        r_phase;
   logic [1:0]  r_idx;
   logic [15:0] r_data;
   logic [3:0]  r_dp;
   logic [3:0]  r_mask;
   logic [3:0]  r_dig;
   logic [7:0]  r_seg;
   logic        r_frame_done;

   logic [3:0]  w_code;
   logic        w_blank_lz;
   logic [3:0]  w_dig;
   logic [7:0]  w_seg;

   // Segment glyphs with the dp bit left dark; non-decimal codes show nothing.
   function automatic logic [7:0] seg_decode(input logic [3:0] code);
      case (code)
         4'd0:    seg_decode = 8'h03;
         4'd1:    seg_decode = 8'h9F;
         4'd2:    seg_decode = 8'h25;
         4'd3:    seg_decode = 8'h0D;
         4'd4:    seg_decode = 8'h99;
         4'd5:    seg_decode = 8'h49;
         4'd6:    seg_decode = 8'h41;
         4'd7:    seg_decode = 8'h1F;
         4'd8:    seg_decode = 8'h01;
         4'd9:    seg_decode = 8'h09;
         default: seg_decode = 8'hFF;
      endcase
   endfunction

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_code     = r_data[{r_idx, 2'b00} +: 4];
      w_blank_lz = 1'b0;
`ifdef SEG_SCAN_LZ_BLANK_EN
      case (r_idx)
         2'd3:    w_blank_lz = (r_data[15:12] == 4'd0);
         2'd2:    w_blank_lz = (r_data[15:8]  == 8'd0);
         2'd1:    w_blank_lz = (r_data[15:4]  == 12'd0);
         default: w_blank_lz = 1'b0;
      endcase
`endif
      w_dig = 4'hF;
      w_seg = 8'hFF;
      if (r_state == SHOW && !(r_phase && r_mask[r_idx])) begin
         w_dig = ~(4'b0001 << r_idx);
         w_seg = w_blank_lz ? 8'hFF : seg_decode(w_code);
         if (r_dp[r_idx]) w_seg[0] = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_fcnt       <= '0;
         r_phase      <= 1'b0;
         r_idx        <= '0;
         r_data       <= '0;
         r_dp         <= '0;
         r_mask       <= '0;
         r_dig        <= 4'hF;
         r_seg        <= 8'hFF;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         r_dig        <= w_dig;
         r_seg        <= w_seg;
         if (!en) begin
            // Blink phase survives a disable so a restart keeps the blink rhythm.
            r_state <= IDLE;
            r_cnt   <= '0;
            r_fcnt  <= '0;
            r_idx   <= '0;
            r_dig   <= 4'hF;
            r_seg   <= 8'hFF;
         end else begin
            case (r_state)
               IDLE: begin
                  r_state <= BLANK;
                  r_cnt   <= '0;
                  r_idx   <= '0;
                  r_data  <= data_in;
                  r_dp    <= dp_in;
                  r_mask  <= blink_mask;
               end
               BLANK: begin
                  if (r_cnt == BLANK_LAST) begin
                     r_state <= SHOW;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + 16'd1;
                  end
               end
               SHOW: begin
                  if (r_cnt == SHOW_LAST) begin
                     r_state <= BLANK;
                     r_cnt   <= '0;
                     r_idx   <= r_idx + 2'd1;
                     if (r_idx == 2'd3) begin
                        // Frame boundary: take a fresh snapshot so a frame never tears.
                        r_frame_done <= 1'b1;
                        r_data       <= data_in;
                        r_dp         <= dp_in;
                        r_mask       <= blink_mask;
                        if (r_fcnt == FRAME_LAST) begin
                           r_fcnt  <= '0;
                           r_phase <= ~r_phase;
                        end else begin
                           r_fcnt <= r_fcnt + 10'd1;
                        end
                     end
                  end else begin
                     r_cnt <= r_cnt + 16'd1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign dig        = r_dig;
   assign seg        = r_seg;
   assign scan_idx   = r_idx;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_sched.sv
// Self-checking bench for seg_scan_sched: frame-position model plus directed literal checks.
module tb_seg_scan_sched;

   localparam int SD = 8;
   localparam int BC = 2;
   localparam int BF = 2;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [15:0] data_in;
   logic [3:0]  dp_in;
   logic [3:0]  blink_mask;
   logic [3:0]  dig;
   logic [7:0]  seg;
   logic [1:0]  scan_idx;
   logic        frame_done;

   int n_checks = 0;
   int n_errors = 0;
   int k = 0;

   seg_scan_sched #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .dp_in(dp_in),
      .blink_mask(blink_mask), .dig(dig), .seg(seg), .scan_idx(scan_idx),
      .frame_done(frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model: position within a 4*SD-cycle frame ----------------
   bit          m_run;
   int          m_t;
   int          m_frames;
   bit          m_phase;
   logic [15:0] m_data;
   logic [3:0]  m_dp;
   logic [3:0]  m_mask;
   logic [3:0]  e_dig;
   logic [7:0]  e_seg;
   logic [1:0]  e_idx;
   logic        e_fd;

   function automatic logic [7:0] glyph(input logic [3:0] c);
      case (c)
         4'd0: return 8'h03; 4'd1: return 8'h9F; 4'd2: return 8'h25; 4'd3: return 8'h0D;
         4'd4: return 8'h99; 4'd5: return 8'h49; 4'd6: return 8'h41; 4'd7: return 8'h1F;
         4'd8: return 8'h01; 4'd9: return 8'h09;
         default: return 8'hFF;
      endcase
   endfunction

   task automatic frame_view(input int t, output logic [3:0] d, output logic [7:0] s);
      int   slot;
      logic lz;
      slot = t / SD;
      d = 4'hF;
      s = 8'hFF;
      lz = 1'b0;
`ifdef SEG_SCAN_LZ_BLANK_EN
      lz = (slot > 0) && ((m_data >> (4 * slot)) == 16'd0);
`endif
      if ((t % SD) >= BC && !(m_phase && m_mask[slot])) begin
         d = 4'hF ^ (4'(1) << slot);
         s = lz ? 8'hFF : glyph(4'((m_data >> (4 * slot)) & 16'hF));
         if (m_dp[slot]) s = s & 8'hFE;
      end
   endtask

   task automatic take_snapshot();
      m_data = data_in;
      m_dp   = dp_in;
      m_mask = blink_mask;
   endtask

   initial begin
      m_run = 0; m_t = 0; m_frames = 0; m_phase = 0;
      m_data = '0; m_dp = '0; m_mask = '0;
      e_dig = 4'hF; e_seg = 8'hFF; e_idx = 2'd0; e_fd = 1'b0;
      forever begin
         @(posedge clk or negedge rst_n);
         e_fd = 1'b0;
         if (!rst_n) begin
            m_run = 0; m_t = 0; m_frames = 0; m_phase = 0;
            e_dig = 4'hF; e_seg = 8'hFF; e_idx = 2'd0;
         end else if (!en) begin
            m_run = 0; m_t = 0; m_frames = 0;
            e_dig = 4'hF; e_seg = 8'hFF; e_idx = 2'd0;
         end else if (!m_run) begin
            m_run = 1; m_t = 0;
            take_snapshot();
            e_dig = 4'hF; e_seg = 8'hFF; e_idx = 2'd0;
         end else begin
            frame_view(m_t, e_dig, e_seg);
            m_t++;
            if (m_t == 4 * SD) begin
               m_t  = 0;
               e_fd = 1'b1;
               m_frames++;
               if (m_frames == BF) begin
                  m_frames = 0;
                  m_phase  = !m_phase;
               end
               take_snapshot();
            end
            e_idx = 2'(m_t / SD);
         end
      end
   end

   // Compare every cycle on the inactive edge.
   initial begin
      forever begin
         @(negedge clk);
         check("cmp_dig", {12'd0, dig}, {12'd0, e_dig});
         check("cmp_seg", {8'd0, seg}, {8'd0, e_seg});
         check("cmp_idx", {14'd0, scan_idx}, {14'd0, e_idx});
         check("cmp_fd", {15'd0, frame_done}, {15'd0, e_fd});
      end
   end

   // ---------------- directed stimulus; k counts clock edges since the en-start ----------------
   task automatic tick();
      @(posedge clk);
      #2;
      k++;
   endtask

   task automatic go(input int target);
      while (k < target) tick();
   endtask

   initial begin
      rst_n = 1'b1; en = 1'b1; data_in = 16'h1234; dp_in = 4'b0000; blink_mask = 4'b0000;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_dig", {12'd0, dig}, 16'h000F);
      check("rst_seg", {8'd0, seg}, 16'h00FF);
      check("rst_idx", {14'd0, scan_idx}, 16'h0000);
      check("rst_fd", {15'd0, frame_done}, 16'h0000);
      rst_n = 1'b1;

      go(3);   check("d0_blank_dig", {12'd0, dig}, 16'h000F);
      go(4);   check("d0_dig", {12'd0, dig}, 16'h000E);
               check("d0_seg", {8'd0, seg}, 16'h0099);
      go(12);  check("d1_dig", {12'd0, dig}, 16'h000D);
               check("d1_seg", {8'd0, seg}, 16'h000D);
               check("d1_idx", {14'd0, scan_idx}, 16'h0001);
      go(13);  data_in = 16'h5678;
      go(20);  check("tear_d2_dig", {12'd0, dig}, 16'h000B);
               check("tear_d2_seg", {8'd0, seg}, 16'h0025);
      go(28);  check("tear_d3_seg", {8'd0, seg}, 16'h009F);
               check("d3_dig", {12'd0, dig}, 16'h0007);
      go(32);  check("fd_before", {15'd0, frame_done}, 16'h0000);
      go(33);  check("fd_pulse", {15'd0, frame_done}, 16'h0001);
               check("fd_idx_wrap", {14'd0, scan_idx}, 16'h0000);
      go(34);  check("fd_after", {15'd0, frame_done}, 16'h0000);
      go(36);  check("new_d0_seg", {8'd0, seg}, 16'h0001);
      go(44);  check("new_d1_seg", {8'd0, seg}, 16'h001F);
               data_in = 16'h1234; dp_in = 4'b0001; blink_mask = 4'b1000;
      go(68);  check("dp_d0_seg", {8'd0, seg}, 16'h0098);
      go(92);  check("blink_f2_dig", {12'd0, dig}, 16'h000F);
               check("blink_f2_seg", {8'd0, seg}, 16'h00FF);
      go(124); check("blink_f3_dig", {12'd0, dig}, 16'h000F);
      go(156); check("blink_f4_dig", {12'd0, dig}, 16'h0007);
               check("blink_f4_seg", {8'd0, seg}, 16'h009F);
               data_in = 16'h00A0;
      go(172); check("bad_code_dig", {12'd0, dig}, 16'h000D);
               check("bad_code_seg", {8'd0, seg}, 16'h00FF);
`ifdef SEG_SCAN_LZ_BLANK_EN
      go(180); check("a0_d2_seg", {8'd0, seg}, 16'h00FF);
`else
      go(180); check("a0_d2_seg", {8'd0, seg}, 16'h0003);
`endif
               data_in = 16'h0040; dp_in = 4'b0000; blink_mask = 4'b0000;
      go(196); check("lz_d0_seg", {8'd0, seg}, 16'h0003);
      go(204); check("lz_d1_seg", {8'd0, seg}, 16'h0099);
`ifdef SEG_SCAN_LZ_BLANK_EN
      go(212); check("lz_d2_seg", {8'd0, seg}, 16'h00FF);
               check("lz_d2_dig", {12'd0, dig}, 16'h000B);
      go(220); check("lz_d3_seg", {8'd0, seg}, 16'h00FF);
`else
      go(212); check("lz_d2_seg", {8'd0, seg}, 16'h0003);
               check("lz_d2_dig", {12'd0, dig}, 16'h000B);
      go(220); check("lz_d3_seg", {8'd0, seg}, 16'h0003);
`endif
      go(245); check("pre_drop_dig", {12'd0, dig}, 16'h000B);
               en = 1'b0;
      go(246); check("drop_dig", {12'd0, dig}, 16'h000F);
               check("drop_seg", {8'd0, seg}, 16'h00FF);
               check("drop_idx", {14'd0, scan_idx}, 16'h0000);
      go(260); en = 1'b1;
      go(261); check("restart_idx", {14'd0, scan_idx}, 16'h0000);
               check("restart_dig", {12'd0, dig}, 16'h000F);
      go(264); check("restart_d0_dig", {12'd0, dig}, 16'h000E);
               check("restart_d0_seg", {8'd0, seg}, 16'h0003);
      go(292); en = 1'b0;
      go(293); check("simul_fd", {15'd0, frame_done}, 16'h0000);
               check("simul_dig", {12'd0, dig}, 16'h000F);
      go(300);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
